// File: rtl/fpdiv_vec_pkg.sv
// Shared types and constants for the fpdiv test-vector line writer.
package fpdiv_vec_pkg;

  localparam int LINE_LEN = 30;

  localparam logic [4:0] SEP0_IDX = 5'd8;
  localparam logic [4:0] SEP1_IDX = 5'd17;
  localparam logic [4:0] SEP2_IDX = 5'd26;
  localparam logic [4:0] RM_IDX   = 5'd27;
  localparam logic [4:0] NL_IDX   = 5'(LINE_LEN - 1);

  localparam logic [7:0] CH_SEP  = 8'h5F;
  localparam logic [7:0] CH_NL   = 8'h0A;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_BAD  = 8'h3F;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [1:0]  round_mode;
  } vec_rec_t;

  // A single binary digit rendered as '0' or '1'.
  function automatic logic [7:0] bit_to_ascii(input logic b);
    return CH_ZERO + {7'd0, b};
  endfunction

endpackage

// File: rtl/fpdiv_vector_writer_nibble_to_ascii.sv
// Combinational hex-digit encoder: one nibble to its ASCII character.
module nibble_to_ascii
  import fpdiv_vec_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits 0-9 map onto '0'..'9', 10-15 onto 'a'..'f' or 'A'..'F'.
  always_comb begin
    ascii = CH_ZERO;
    if (nibble < 4'd10) begin
      ascii = CH_ZERO + {4'h0, nibble};
    end else if (HEX_UPPER) begin
      ascii = 8'h41 + {4'h0, nibble - 4'd10};
    end else begin
      ascii = 8'h61 + {4'h0, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/fpdiv_vector_writer.sv
// Serialises one fpdiv record into "hhhhhhhh_hhhhhhhh_hhhhhhhh_bb\n",
// one character per valid/ready handshake on the output side.
module fpdiv_vector_writer
  import fpdiv_vec_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             test_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      dividend,
  input  logic [31:0]      divisor,
  input  logic [31:0]      quotient,
  input  logic [1:0]       round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             line_done,
  output logic [CNT_W-1:0] line_count
);

  state_t           state_r;
  logic [4:0]       char_idx_r;
  vec_rec_t         rec_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             line_done_r;
  logic [CNT_W-1:0] line_count_r;

  logic [31:0]      sel_word_s;
  logic [2:0]       nib_pos_s;
  logic [3:0]       nib_s;
  logic             is_hex_s;
  logic [7:0]       fixed_char_s;
  logic [7:0]       hex_char_s;
  logic [7:0]       out_char_s;

  // Pick the field and nibble position for hex positions, or a fixed glyph otherwise.
  always_comb begin
    sel_word_s   = 32'h0000_0000;
    nib_pos_s    = 3'd0;
    is_hex_s     = 1'b0;
    fixed_char_s = CH_BAD;
    if (char_idx_r < SEP0_IDX) begin
      sel_word_s = rec_r.dividend;
      nib_pos_s  = 3'(SEP0_IDX - 5'd1 - char_idx_r);
      is_hex_s   = 1'b1;
    end else if (char_idx_r == SEP0_IDX) begin
      fixed_char_s = CH_SEP;
    end else if (char_idx_r < SEP1_IDX) begin
      sel_word_s = rec_r.divisor;
      nib_pos_s  = 3'(SEP1_IDX - 5'd1 - char_idx_r);
      is_hex_s   = 1'b1;
    end else if (char_idx_r == SEP1_IDX) begin
      fixed_char_s = CH_SEP;
    end else if (char_idx_r < SEP2_IDX) begin
      sel_word_s = rec_r.quotient;
      nib_pos_s  = 3'(SEP2_IDX - 5'd1 - char_idx_r);
      is_hex_s   = 1'b1;
    end else if (char_idx_r == SEP2_IDX) begin
      fixed_char_s = CH_SEP;
    end else if (char_idx_r == RM_IDX) begin
      fixed_char_s = bit_to_ascii(rec_r.round_mode[1]);
    end else if (char_idx_r == RM_IDX + 5'd1) begin
      fixed_char_s = bit_to_ascii(rec_r.round_mode[0]);
    end else if (char_idx_r == NL_IDX) begin
      fixed_char_s = CH_NL;
    end else begin
      fixed_char_s = CH_BAD;
    end
  end

  assign nib_s = sel_word_s[{nib_pos_s, 2'b00} +: 4];

  nibble_to_ascii #(
    .HEX_UPPER(HEX_UPPER)
  ) u_nib (
    .nibble(nib_s),
    .ascii (hex_char_s)
  );

  // Character is only meaningful while emitting; idle output reads as zero.
  always_comb begin
    out_char_s = 8'h00;
    if (out_valid_r) begin
      out_char_s = is_hex_s ? hex_char_s : fixed_char_s;
    end else begin
      out_char_s = 8'h00;
    end
  end

  // Line FSM: capture a record in IDLE, step through characters in EMIT.
  always_ff @(posedge test_clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      char_idx_r   <= 5'd0;
      rec_r        <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      line_done_r  <= 1'b0;
      line_count_r <= '0;
    end else begin
      line_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            rec_r       <= {dividend, divisor, quotient, round_mode};
            char_idx_r  <= 5'd0;
            state_r     <= EMIT;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (char_idx_r == NL_IDX) begin
              state_r      <= IDLE;
              char_idx_r   <= 5'd0;
              in_ready_r   <= 1'b1;
              out_valid_r  <= 1'b0;
              line_done_r  <= 1'b1;
              line_count_r <= line_count_r + CNT_W'(1);
            end else if (char_idx_r > NL_IDX) begin
              // Unreachable index: recover to IDLE without counting a line.
              state_r     <= IDLE;
              char_idx_r  <= 5'd0;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
            end else begin
              char_idx_r <= char_idx_r + 5'd1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          char_idx_r  <= 5'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_char   = out_char_s;
  assign line_done  = line_done_r;
  assign line_count = line_count_r;

endmodule

// File: tb/tb_fpdiv_vector_writer.sv
// Directed bench: lowercase instance (a_*) and uppercase, 2-bit counter instance (b_*).
module tb_fpdiv_vector_writer;

  logic        test_clk;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [1:0]  round_mode;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_line_done;
  logic [7:0]  a_out_char;
  logic [15:0] a_line_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_line_done;
  logic [7:0]  b_out_char;
  logic [1:0]  b_line_count;

  int n_pass  = 0;
  int n_total = 0;

  fpdiv_vector_writer dut_a (
    .test_clk  (test_clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .round_mode(round_mode),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_char  (a_out_char),
    .line_done (a_line_done),
    .line_count(a_line_count)
  );

  fpdiv_vector_writer #(
    .HEX_UPPER(1'b1),
    .CNT_W    (2)
  ) dut_b (
    .test_clk  (test_clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .round_mode(round_mode),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_char  (b_out_char),
    .line_done (b_line_done),
    .line_count(b_line_count)
  );

  initial test_clk = 1'b0;
  always #5 test_clk = ~test_clk;

  task automatic test_reset();
    reset = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    dividend = 32'h0; divisor = 32'h0; quotient = 32'h0; round_mode = 2'b00;
    @(posedge test_clk);
    @(posedge test_clk);
    @(negedge test_clk);
    n_total++;
    if ({a_in_ready, a_out_valid, a_out_char, a_line_done, a_line_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0000}) begin
      $display("FAIL reset_a: got rdy=%b vld=%b ch=%h ld=%b cnt=%0d, want rdy=1 vld=0 ch=00 ld=0 cnt=0",
               a_in_ready, a_out_valid, a_out_char, a_line_done, a_line_count);
    end else n_pass++;
    n_total++;
    if ({b_in_ready, b_out_valid, b_out_char, b_line_done, b_line_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 2'b00}) begin
      $display("FAIL reset_b: got rdy=%b vld=%b ch=%h ld=%b cnt=%0d, want rdy=1 vld=0 ch=00 ld=0 cnt=0",
               b_in_ready, b_out_valid, b_out_char, b_line_done, b_line_count);
    end else n_pass++;
    @(posedge test_clk); #1;
    reset = 1'b1;
  endtask

  // Present a record to instance A and wait (bounded) for it to be accepted.
  task automatic send_a(input logic [31:0] n, input logic [31:0] d, input logic [31:0] q, input logic [1:0] rm);
    bit ok;
    ok = 1'b0;
    @(posedge test_clk); #1;
    dividend = n; divisor = d; quotient = q; round_mode = rm;
    a_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge test_clk);
      if (a_in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge test_clk); #1;
    end
    @(posedge test_clk); #1;
    a_in_valid = 1'b0;
    dividend = 32'hA5A5_0000; divisor = 32'h0000_5A5A; quotient = 32'h1234_5678; round_mode = 2'b10;
    n_total++;
    if (!ok) $display("FAIL send_a_accept: in_ready never seen within 100 cycles, want 1");
    else n_pass++;
  endtask

  // Collect one line from instance A; stall pattern 1,0,0,1 when requested.
  task automatic emit_a(input string name, input string exp, input bit stall, output int ncyc);
    logic [7:0] got[$];
    int bad, unstable, ld_early, first_bad, cyc;
    logic pend;
    logic [7:0] pend_ch;
    bad = 0; unstable = 0; ld_early = 0; first_bad = -1; cyc = 0; pend = 1'b0; pend_ch = 8'h00;
    while (got.size() < 30 && cyc < 300) begin
      a_out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      @(negedge test_clk);
      if (a_line_done) ld_early++;
      if (pend && (!a_out_valid || a_out_char !== pend_ch)) unstable++;
      pend = 1'b0;
      if (a_out_valid && a_out_ready) got.push_back(a_out_char);
      else if (a_out_valid) begin
        pend = 1'b1;
        pend_ch = a_out_char;
      end
      cyc++;
      @(posedge test_clk); #1;
    end
    a_out_ready = 1'b1;
    ncyc = cyc;
    if (got.size() != 30) bad++;
    for (int i = 0; i < got.size() && i < 30; i++) begin
      if (got[i] !== exp[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL %s_chars: got %0d chars, %0d wrong (first idx %0d), want 30 chars of %s",
                           name, got.size(), bad, first_bad, exp.substr(0, 28));
    else n_pass++;
    n_total++;
    if (unstable != 0) $display("FAIL %s_stall_stable: %0d changes while stalled, want 0", name, unstable);
    else n_pass++;
    @(negedge test_clk);
    n_total++;
    if ({ld_early, a_line_done, a_in_ready, a_out_valid} !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL %s_line_end: early_ld=%0d ld=%b rdy=%b vld=%b, want 0 1 1 0",
               name, ld_early, a_line_done, a_in_ready, a_out_valid);
    end else n_pass++;
    @(posedge test_clk); #1;
    @(negedge test_clk);
    n_total++;
    if (a_line_done !== 1'b0) $display("FAIL %s_ld_pulse: line_done=%b one cycle later, want 0", name, a_line_done);
    else n_pass++;
  endtask

  task automatic test_basic();
    string exp;
    int ncyc;
    exp = "3f800000_40000000_3f000000_00\n";
    send_a(32'h3f800000, 32'h40000000, 32'h3f000000, 2'b00);
    emit_a("basic", exp, 1'b0, ncyc);
    n_total++;
    if (ncyc != 30) $display("FAIL basic_cycles: %0d cycles, want 30", ncyc);
    else n_pass++;
    n_total++;
    if (a_line_count !== 16'd1) $display("FAIL basic_count: line_count=%0d, want 1", a_line_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    string exp;
    int ncyc;
    exp = "3f800000_40000000_3f000000_00\n";
    send_a(32'h3f800000, 32'h40000000, 32'h3f000000, 2'b00);
    emit_a("stall", exp, 1'b1, ncyc);
    n_total++;
    if (a_line_count !== 16'd2) $display("FAIL stall_count: line_count=%0d, want 2", a_line_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_line();
    string exp;
    int ncyc;
    exp = "01234567_89abcdef_00000000_01\n";
    send_a(32'h3f800000, 32'h40000000, 32'h3f000000, 2'b00);
    a_out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge test_clk); #1;
    end
    reset = 1'b0;
    a_out_ready = 1'b0;
    @(posedge test_clk); #1;
    reset = 1'b1;
    a_out_ready = 1'b1;
    @(negedge test_clk);
    n_total++;
    if ({a_out_valid, a_in_ready, a_line_count, a_line_done} !== {1'b0, 1'b1, 16'd0, 1'b0}) begin
      $display("FAIL reset_mid: vld=%b rdy=%b cnt=%0d ld=%b, want 0 1 0 0",
               a_out_valid, a_in_ready, a_line_count, a_line_done);
    end else n_pass++;
    send_a(32'h01234567, 32'h89abcdef, 32'h00000000, 2'b01);
    emit_a("after_reset", exp, 1'b0, ncyc);
    n_total++;
    if (a_line_count !== 16'd1) $display("FAIL after_reset_count: line_count=%0d, want 1", a_line_count);
    else n_pass++;
  endtask

  // Five records back to back on the uppercase, 2-bit-count instance.
  task automatic test_back_to_back();
    logic [31:0] rn[5], rd[5], rq[5];
    logic [1:0]  rr[5];
    string       exp[5];
    logic [1:0]  exp_cnt[5];
    int          drv_cyc[5];
    logic [7:0]  got[$];
    int sent, done, bad;
    rn[0] = 32'hdeadbeef; rd[0] = 32'h0000000f; rq[0] = 32'hffffffff; rr[0] = 2'b11;
    rn[1] = 32'h01234567; rd[1] = 32'h89abcdef; rq[1] = 32'h00000000; rr[1] = 2'b01;
    rn[2] = 32'h3f800000; rd[2] = 32'h40000000; rq[2] = 32'h3f000000; rr[2] = 2'b10;
    rn[3] = 32'ha5a5a5a5; rd[3] = 32'h5a5a5a5a; rq[3] = 32'hc0ffee00; rr[3] = 2'b00;
    rn[4] = 32'h7f7fffff; rd[4] = 32'h00800000; rq[4] = 32'h7e7fffff; rr[4] = 2'b11;
    exp[0] = "DEADBEEF_0000000F_FFFFFFFF_11\n";
    exp[1] = "01234567_89ABCDEF_00000000_01\n";
    exp[2] = "3F800000_40000000_3F000000_10\n";
    exp[3] = "A5A5A5A5_5A5A5A5A_C0FFEE00_00\n";
    exp[4] = "7F7FFFFF_00800000_7E7FFFFF_11\n";
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
    sent = 0; done = 0;
    b_out_ready = 1'b1;
    @(posedge test_clk); #1;
    n_total++;
    if (b_line_count !== 2'd0) $display("FAIL b2b_start_count: line_count=%0d, want 0", b_line_count);
    else n_pass++;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (b_in_ready && sent < 5) begin
        dividend = rn[sent]; divisor = rd[sent]; quotient = rq[sent]; round_mode = rr[sent];
        b_in_valid = 1'b1;
        drv_cyc[sent] = cyc;
        sent++;
      end else if (b_in_ready) begin
        b_in_valid = 1'b0;
      end else begin
        dividend = $urandom; divisor = $urandom; quotient = $urandom; round_mode = 2'($urandom);
        b_in_valid = 1'b1;
      end
      @(negedge test_clk);
      if (b_out_valid) got.push_back(b_out_char);
      if (b_line_done) begin
        bad = (got.size() == 30) ? 0 : 1;
        for (int i = 0; i < got.size() && i < 30; i++) if (got[i] !== exp[done][i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL b2b_line%0d_chars: %0d chars, %0d wrong, want %s",
                               done, got.size(), bad, exp[done].substr(0, 28));
        else n_pass++;
        n_total++;
        if (b_line_count !== exp_cnt[done]) $display("FAIL b2b_line%0d_count: line_count=%0d, want %0d",
                                                     done, b_line_count, exp_cnt[done]);
        else n_pass++;
        n_total++;
        if (cyc - drv_cyc[done] != 31) $display("FAIL b2b_line%0d_cycles: %0d cycles, want 31",
                                                done, cyc - drv_cyc[done]);
        else n_pass++;
        got.delete();
        done++;
        if (done == 5) break;
      end
      @(posedge test_clk); #1;
    end
    n_total++;
    if (done != 5) $display("FAIL b2b_lines: %0d lines completed within budget, want 5", done);
    else n_pass++;
    @(posedge test_clk); #1;
    b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid_line();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
